// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit with HI/LO result registers.
// 32-cycle shift-add multiply and restoring divide, with a sign fixup in the final cycle.
module mdu #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic [31:0] r_a_raw;
  logic        r_div;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_dz;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_sgn;
  logic [31:0] w_am;
  logic [31:0] w_bm;
  logic [32:0] w_sum;
  logic [64:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_step;
  logic [63:0] w_negp;
  logic [31:0] w_negq;
  logic [31:0] w_negr;
  logic        w_is_md;

  assign w_is_md = (op[2] == 1'b0);
  assign w_sgn   = ~op[0];
  assign w_am    = (w_sgn && A[31]) ? (32'd0 - A) : A;
  assign w_bm    = (w_sgn && B[31]) ? (32'd0 - B) : B;

  // Multiply: accumulate into the upper half while the multiplier shifts out of the lower half.
  assign w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);

  // Divide: {remainder, quotient} shifts left; quotient bits fill in from the bottom.
  assign w_shift = {r_acc, 1'b0};
  assign w_ge    = (w_shift[64:32] >= {1'b0, r_b});
  assign w_diff  = w_shift[63:32] - r_b;

  assign w_step  = r_div ? (w_ge ? {w_diff, w_shift[31:1], 1'b1} : w_shift[63:0])
                         : {w_sum, r_acc[31:1]};

  assign w_negp  = 64'd0 - r_acc;
  assign w_negq  = 32'd0 - r_acc[31:0];
  assign w_negr  = 32'd0 - r_acc[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_a_raw <= '0;
      r_div   <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && w_is_md) begin
            r_acc   <= {32'd0, w_am};
            r_b     <= w_bm;
            r_a_raw <= A;
            r_div   <= op[1];
            r_qneg  <= w_sgn & (A[31] ^ B[31]);
            r_rneg  <= w_sgn & A[31];
            r_dz    <= (B == 32'd0);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else if (start && op == 3'b100) begin
            r_hi <= A;
          end else if (start && op == 3'b101) begin
            r_lo <= A;
          end
        end
        RUN: begin
          r_acc <= w_step;
          if (r_cnt == 6'(ITER - 1)) begin
            r_cnt   <= '0;
            r_state <= FIN;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        FIN: begin
          if (r_div && r_dz) begin
            r_hi <= r_a_raw;
            r_lo <= 32'hFFFF_FFFF;
          end else if (r_div) begin
            r_hi <= r_rneg ? w_negr : r_acc[63:32];
            r_lo <= r_qneg ? w_negq : r_acc[31:0];
          end else begin
            {r_hi, r_lo} <= r_qneg ? w_negp : r_acc;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for the multiply/divide unit.
module tb_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu #(.ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-28s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issues one MULT/DIV-family op, scrambles inputs after E0, optionally fires an MTLO mid-run.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit inj);
    int n;
    logic [31:0] h0;
    logic [31:0] l0;
    bit moved;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b100; A = 32'hA5A5_A5A5; B = 32'h5A5A_5A5A;
    chk({tag, " busy@E0"}, {63'd0, busy}, 64'd1);
    chk({tag, " done@E0"}, {63'd0, done}, 64'd0);
    h0 = hi; l0 = lo; n = 0; moved = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      if (inj && n == 5) begin
        start = 1'b1; op = 3'b101; A = 32'h0000_0055;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && (hi !== h0 || lo !== l0 || busy !== 1'b1)) moved = 1;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " stable"}, {63'd0, moved}, 64'd0);
    chk({tag, " busy@done"}, {63'd0, busy}, 64'd0);
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    $display("txn %s op=%0d A=%h B=%h -> hi=%h lo=%h", tag, o, a, b, hi, lo);
  endtask

  initial begin
    int k;
    bit saw_done;
    rst = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
    #3;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;

    @(negedge clk); op = 3'b100; A = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("mthi hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
    chk("mthi busy", {63'd0, busy}, 64'd0);
    chk("mthi done", {63'd0, done}, 64'd0);

    @(negedge clk); op = 3'b101; A = 32'h1357_2468; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("mtlo lo", {32'd0, lo}, {32'd0, 32'h1357_2468});
    chk("mtlo hi kept", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});

    @(negedge clk); op = 3'b110; A = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); op = 3'b111;
    @(posedge clk); #1; start = 1'b0;
    chk("reserved busy", {63'd0, busy}, 64'd0);
    chk("reserved hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1357_2468});
    @(posedge clk); #1;
    chk("reserved no start", {63'd0, busy}, 64'd0);

    run_op("multu max",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult -3*7",   3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult min*min+mtlo", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1);
    run_op("div -7/2",    3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2",    3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    run_op("divu 100/7",  3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op("divu by 0",   3'b011, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_op("div min/-1",  3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_op("div -7/0",    3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

    // Abort a MULTU with reset around E10, then rerun it.
    @(negedge clk); op = 3'b001; A = 32'd5; B = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort hi", {32'd0, hi}, 64'd0);
    chk("abort lo", {32'd0, lo}, 64'd0);
    chk("abort busy", {63'd0, busy}, 64'd0);
    saw_done = 0;
    @(negedge clk); rst = 1'b0;
    for (k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    chk("abort no done", {63'd0, saw_done}, 64'd0);
    run_op("multu 5*6",   3'b001, 32'd5,         32'd6,         32'd0,         32'd30,        1'b0);
    @(posedge clk); #1;
    chk("done one cycle", {63'd0, done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
